ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction-fetch stage directly downstream of the PC register. Each cycle it takes `cur_pc`, issues an in-order request to instruction memory, and tracks the PC of every outstanding request. Returned instructions are buffered with their PC in a small FIFO and handed to decode over a valid/ready handshake. It drives `pc_stop` back to the PC so the PC advances only when a fetch is actually accepted. A flush drops all buffered and in-flight fetches.

## Interface
- `DEPTH`, 2: FIFO entries; this is also the maximum number of in-flight plus buffered fetches (power of two, ≥2).
- `XLEN`, 32: address and instruction width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `cur_pc`  in  XLEN  current PC from the PC register.
- `pc_stop`  out  1  1 = PC must hold; 0 = PC advances this cycle.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  XLEN  fetch address; always equals `cur_pc`.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response valid. Responses return in request order, at least 1 cycle after grant.
- `imem_rdata`  in  XLEN  response instruction.
- `flush`  in  1  redirect or branch taken: discard all fetches.
- `if_valid`  out  1  FIFO head valid to decode.
- `if_pc`  out  XLEN  PC of the head entry.
- `if_instr`  out  XLEN  instruction of the head entry.
- `id_ready`  in  1  decode accepts the head.

## Operation
- Counters:
  - `inflight`: granted requests not yet responded to.
  - `count`: FIFO occupancy.
  - `discard`: in-flight responses still to be dropped.
- PC tag queue, DEPTH entries: `cur_pc` is pushed on every grant and popped on every non-discarded response.
- Request rule: `imem_req = !flush && (inflight + count < DEPTH)`. A fetch is issued only if it is guaranteed a FIFO slot.
- `pc_stop = !(imem_req && imem_gnt)`.
- Response with `discard == 0`: push {tag-queue head, `imem_rdata`} into the FIFO and pop the tag queue.
- Response with `discard > 0`: drop it and decrement `discard`.
- Pop: FIFO head is removed when `if_valid && id_ready`.
- Flush, effective at the edge:
  - FIFO and tag queue emptied; `count` = 0.
  - `discard` = `inflight` (net of any response arriving in the flush cycle).
  - `inflight` = 0.
- Flush interactions in the same cycle:
  - No request is issued during a flush cycle.
  - A response arriving in the flush cycle is dropped.
  - A pop in the flush cycle is a no-op.
- Counter updates:
  - `inflight` += grant, −= non-discarded response.
  - `count` += push, −= pop.
  - Simultaneous push and pop leaves `count` unchanged.
- A response with `inflight == 0 && discard == 0` is a protocol error; it is ignored.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counters are log2(DEPTH)+1 bits.

## Timing
- Reset values (`rst` = 0, asynchronous):
  - All counters and pointers 0.
  - `if_valid` = 0, `if_pc` = 0, `if_instr` = 0.
- Immediately after reset release: `imem_req` = 1, `pc_stop` = !`imem_gnt`.
- Reset asserted mid-operation clears all state at once; responses already in flight after reset must not occur (memory is reset with the core).
- Request, `imem_addr` and `pc_stop` are combinational from state, `flush` and `imem_gnt`. The PC sees `pc_stop` in the same cycle as the grant.
- Latency:
  - Response at edge t → `if_valid`, `if_pc`, `if_instr` visible after edge t (registered FIFO, no bypass).
  - Minimum grant-to-decode: 2 cycles.
- `if_pc` and `if_instr` are stable while `if_valid && !id_ready`.
- Full: `inflight + count == DEPTH` → `imem_req` = 0, `pc_stop` = 1.
- A pop in cycle t frees a slot, so a request can be issued in cycle t+1.
- Empty: `if_valid` = 0; `if_pc` and `if_instr` hold their last values.

## Test plan
- Reset, then `imem_gnt` = 1 always and 1-cycle response latency, `id_ready` = 1, PC incrementing by 4 from 0:
  - `if_valid` rises 2 cycles after the first grant.
  - `if_pc` = 0, 4, 8, … on consecutive cycles, with `if_instr` matching.
  - `pc_stop` stays 0.
- Backpressure: `id_ready` = 0 from start, DEPTH = 2:
  - Exactly 2 grants, then `imem_req` = 0 and `pc_stop` = 1.
  - `if_pc` = 0 held.
  - Raise `id_ready` → one pop, then a new request in the next cycle.
- Grant stall: `imem_gnt` = 0 for 3 cycles → `pc_stop` = 1 for those 3 cycles and `cur_pc` unchanged; the grant on cycle 4 gives `pc_stop` = 0.
- Flush with 2 in flight (3-cycle response latency):
  - Both late responses are dropped and `if_valid` stays 0.
  - Fetch from the redirected PC 0x100 appears as `if_pc` = 0x100.
- Flush in the same cycle as a response and a pop:
  - FIFO empty afterwards and `discard` = remaining `inflight`.
  - No request in the flush cycle.
- Async reset asserted between clock edges with a full FIFO: `if_valid` = 0 immediately, before the next edge.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order instruction fetch stage between the PC register and decode.
// Issues one fetch per cycle while a FIFO slot is guaranteed, tags each outstanding
// request with its PC, buffers returned instructions and hands them to decode.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   cur_pc              current PC from the PC register
//   pc_stop             1 = PC holds this cycle
//   imem_req/addr/gnt   fetch request channel to instruction memory
//   imem_rvalid/rdata   in-order response channel
//   flush               drop all buffered and in-flight fetches
//   if_valid/pc/instr   registered FIFO head towards decode
//   id_ready            decode accepts the head
module ifetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] cur_pc,
  output logic            pc_stop,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            flush,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            id_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [CW-1:0]   discard_q,  discard_d;
  logic [AW-1:0]   tag_wr_q,   tag_wr_d;
  logic [AW-1:0]   tag_rd_q,   tag_rd_d;
  logic [AW-1:0]   wr_q,       wr_d;
  logic [AW-1:0]   rd_q,       rd_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q,    if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;

  logic [XLEN-1:0] tag_mem_q   [DEPTH];
  logic [XLEN-1:0] fifo_pc_q   [DEPTH];
  logic [XLEN-1:0] fifo_instr_q[DEPTH];

  logic [CW-1:0]   occupancy;
  logic            grant;
  logic            resp_keep;
  logic            resp_drop;
  logic            resp_any;
  logic            pop;

  // Request side: only ask when a FIFO slot is reserved for the answer.
  always_comb begin
    occupancy = inflight_q + count_q;
    imem_req  = !flush && (occupancy < CW'(DEPTH));
    imem_addr = cur_pc;
    grant     = imem_req && imem_gnt;
    pc_stop   = !grant;
  end

  // Response classification; an unexpected response (nothing outstanding) is ignored.
  always_comb begin
    resp_drop = imem_rvalid && (discard_q != '0);
    resp_keep = imem_rvalid && !flush && (discard_q == '0) && (inflight_q != '0);
    resp_any  = imem_rvalid && ((discard_q != '0) || (inflight_q != '0));
    pop       = if_valid_q && id_ready && !flush;
  end

  // Next-state for counters, pointers and the registered head.
  always_comb begin
    inflight_d = inflight_q;
    count_d    = count_q;
    discard_d  = discard_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    if_valid_d = 1'b0;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    if (flush) begin
      // Everything outstanding, minus a response consumed this cycle, must be dropped later.
      inflight_d = '0;
      count_d    = '0;
      discard_d  = discard_q + inflight_q - CW'(resp_any);
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      wr_d       = '0;
      rd_d       = '0;
    end else begin
      inflight_d = inflight_q + CW'(grant) - CW'(resp_keep);
      count_d    = count_q + CW'(resp_keep) - CW'(pop);
      discard_d  = discard_q - CW'(resp_drop);
      tag_wr_d   = tag_wr_q + AW'(grant);
      tag_rd_d   = tag_rd_q + AW'(resp_keep);
      wr_d       = wr_q + AW'(resp_keep);
      rd_d       = rd_q + AW'(pop);
    end

    // Head register: the entry being written this cycle becomes head only when the FIFO
    // is otherwise empty; when empty the head holds its last value.
    if (count_d != '0) begin
      if_valid_d = 1'b1;
      if (resp_keep && (rd_d == wr_q)) begin
        if_pc_d    = tag_mem_q[tag_rd_q];
        if_instr_d = imem_rdata;
      end else begin
        if_pc_d    = fifo_pc_q[rd_d];
        if_instr_d = fifo_instr_q[rd_d];
      end
    end
  end

  // Control state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
      count_q    <= '0;
      discard_q  <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      discard_q  <= discard_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  // Storage arrays; contents are qualified by the pointers so need no reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_mem_q[tag_wr_q] <= cur_pc;
    end
    if (resp_keep) begin
      fifo_pc_q[wr_q]    <= tag_mem_q[tag_rd_q];
      fifo_instr_q[wr_q] <= imem_rdata;
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: PC register model, in-order memory model with
// configurable latency, and a scoreboard of granted PCs checked at each decode pop.
module tb_ifetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  typedef struct {
    logic [XLEN-1:0] addr;
    int unsigned     due;
  } mreq_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] cur_pc;
  logic            pc_stop;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            flush;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            id_ready;

  int n_cmp = 0;
  int n_bad = 0;

  mreq_t           mem_q[$];
  logic [XLEN-1:0] sb_q[$];
  int unsigned     cyc;
  int unsigned     lat;

  logic            obs_req, obs_stop, obs_grant, obs_valid, obs_pop, obs_have;
  logic [XLEN-1:0] obs_pc, obs_instr, obs_addr, obs_cur, obs_exp;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .cur_pc     (cur_pc),
    .pc_stop    (pc_stop),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .id_ready   (id_ready)
  );

  function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // One clock cycle: observe at the falling edge, then advance PC and memory models.
  task automatic tick();
    @(negedge clk);
    obs_req   = imem_req;
    obs_stop  = pc_stop;
    obs_grant = imem_req && imem_gnt;
    obs_valid = if_valid;
    obs_pc    = if_pc;
    obs_instr = if_instr;
    obs_addr  = imem_addr;
    obs_cur   = cur_pc;
    obs_pop   = if_valid && id_ready && !flush;
    obs_have  = 1'b0;
    obs_exp   = '0;
    if (obs_pop && sb_q.size() != 0) begin
      obs_have = 1'b1;
      obs_exp  = sb_q.pop_front();
    end
    if (flush) sb_q.delete();
    if (obs_grant) begin
      mem_q.push_back('{addr: imem_addr, due: cyc + lat});
      sb_q.push_back(cur_pc);
    end
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    if (!obs_stop) cur_pc = cur_pc + 32'd4;
    imem_rvalid = 1'b0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    flush       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    cur_pc      = '0;
    mem_q.delete();
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    imem_gnt = 1'b0;
    #3;
    n_cmp++;
    if (if_valid !== 1'b0 || if_pc !== '0 || if_instr !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: valid=%b pc=%h instr=%h want 0/0/0", if_valid, if_pc, if_instr);
    end
    do_reset();
    #1;
    n_cmp++;
    if (imem_req !== 1'b1 || pc_stop !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_nognt: req=%b stop=%b want 1/1", imem_req, pc_stop);
    end
    imem_gnt = 1'b1;
    #1;
    n_cmp++;
    if (pc_stop !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_gnt: stop=%b want 0", pc_stop);
    end
  endtask

  task automatic test_stream();
    int g0 = -1, v0 = -1, stops = 0, gaps = 0, addr_bad = 0, pops = 0;
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b1; lat = 1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (obs_grant && g0 < 0) g0 = i;
      if (obs_valid && v0 < 0) v0 = i;
      if (obs_stop) stops++;
      if (v0 >= 0 && !obs_valid) gaps++;
      if (obs_addr !== obs_cur) addr_bad++;
      if (obs_pop) begin
        n_cmp++;
        if (!obs_have || obs_pc !== obs_exp || obs_pc !== 32'(pops * 4) || obs_instr !== instr_of(obs_exp)) begin
          n_bad++;
          $display("FAIL stream_pop: pc=%h instr=%h want pc=%h instr=%h", obs_pc, obs_instr, 32'(pops * 4), instr_of(32'(pops * 4)));
        end
        pops++;
      end
    end
    n_cmp++;
    if (g0 < 0 || v0 - g0 != 2) begin n_bad++; $display("FAIL stream_latency: grant@%0d valid@%0d want 2 apart", g0, v0); end
    n_cmp++;
    if (stops != 0) begin n_bad++; $display("FAIL stream_pc_stop: stop cycles %0d want 0", stops); end
    n_cmp++;
    if (gaps != 0) begin n_bad++; $display("FAIL stream_gaps: invalid cycles %0d want 0", gaps); end
    n_cmp++;
    if (addr_bad != 0) begin n_bad++; $display("FAIL stream_addr: bad cycles %0d want 0", addr_bad); end
    n_cmp++;
    if (pops != 22) begin n_bad++; $display("FAIL stream_pops: %0d want 22", pops); end
  endtask

  task automatic test_backpressure();
    int grants = 0, held_bad = 0;
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b0; lat = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_grant) grants++;
      if (i >= 2 && (obs_valid !== 1'b1 || obs_pc !== 32'h0 || obs_instr !== instr_of(32'h0))) held_bad++;
    end
    n_cmp++;
    if (grants != DEPTH) begin n_bad++; $display("FAIL bp_grants: %0d want %0d", grants, DEPTH); end
    n_cmp++;
    if (obs_req !== 1'b0 || obs_stop !== 1'b1) begin n_bad++; $display("FAIL bp_full: req=%b stop=%b want 0/1", obs_req, obs_stop); end
    n_cmp++;
    if (held_bad != 0) begin n_bad++; $display("FAIL bp_head_held: bad cycles %0d want 0", held_bad); end
    id_ready = 1'b1;
    tick();
    n_cmp++;
    if (!obs_pop || !obs_have || obs_pc !== 32'h0 || obs_grant !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_pop: pop=%b pc=%h grant=%b want 1/0/0", obs_pop, obs_pc, obs_grant);
    end
    id_ready = 1'b0;
    tick();
    n_cmp++;
    if (obs_grant !== 1'b1 || obs_pc !== 32'h4) begin
      n_bad++;
      $display("FAIL bp_refill: grant=%b head=%h want 1/00000004", obs_grant, obs_pc);
    end
    tick();
    n_cmp++;
    if (obs_req !== 1'b0) begin n_bad++; $display("FAIL bp_refull: req=%b want 0", obs_req); end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    imem_gnt = 1'b0; id_ready = 1'b1; lat = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs_stop !== 1'b1 || obs_cur !== 32'h0) begin
        n_bad++;
        $display("FAIL stall_cycle%0d: stop=%b pc=%h want 1/00000000", i, obs_stop, obs_cur);
      end
    end
    imem_gnt = 1'b1;
    tick();
    n_cmp++;
    if (obs_stop !== 1'b0 || obs_cur !== 32'h0) begin
      n_bad++;
      $display("FAIL stall_release: stop=%b pc=%h want 0/00000000", obs_stop, obs_cur);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (obs_pop) begin
        n_cmp++;
        if (!obs_have || obs_pc !== obs_exp || obs_instr !== instr_of(obs_exp)) begin
          n_bad++;
          $display("FAIL stall_pop: pc=%h instr=%h want pc=%h", obs_pc, obs_instr, obs_exp);
        end
      end
    end
  endtask

  task automatic test_flush();
    int first_k = -1;
    logic [XLEN-1:0] first_pc = '0;
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b1; lat = 3;
    tick();
    tick();
    flush = 1'b1;
    tick();
    n_cmp++;
    if (obs_req !== 1'b0 || obs_stop !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_no_req: req=%b stop=%b want 0/1", obs_req, obs_stop);
    end
    flush = 1'b0; cur_pc = 32'h100; lat = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (obs_valid && first_k < 0) begin first_k = k; first_pc = obs_pc; end
      if (obs_pop) begin
        n_cmp++;
        if (!obs_have || obs_pc !== obs_exp || obs_instr !== instr_of(obs_exp)) begin
          n_bad++;
          $display("FAIL flush_pop: pc=%h instr=%h want pc=%h", obs_pc, obs_instr, obs_exp);
        end
      end
    end
    n_cmp++;
    if (first_k != 3 || first_pc !== 32'h100) begin
      n_bad++;
      $display("FAIL flush_redirect: first valid @%0d pc=%h want @3 pc=00000100", first_k, first_pc);
    end
  endtask

  task automatic test_flush_collide();
    int first_k = -1;
    logic [XLEN-1:0] first_pc = '0;
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b0; lat = 2;
    repeat (3) tick();
    id_ready = 1'b1; flush = 1'b1;
    tick();
    n_cmp++;
    if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_grant !== 1'b0) begin
      n_bad++;
      $display("FAIL collide_cycle: req=%b valid=%b grant=%b want 0/1/0", obs_req, obs_valid, obs_grant);
    end
    flush = 1'b0; cur_pc = 32'h200; lat = 1;
    n_cmp++;
    if (u_dut.discard_q !== 3'd1 || u_dut.count_q !== 3'd0 || u_dut.inflight_q !== 3'd0) begin
      n_bad++;
      $display("FAIL collide_counters: discard=%0d count=%0d inflight=%0d want 1/0/0", u_dut.discard_q, u_dut.count_q, u_dut.inflight_q);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (obs_valid && first_k < 0) begin first_k = k; first_pc = obs_pc; end
      if (obs_pop) begin
        n_cmp++;
        if (!obs_have || obs_pc !== obs_exp || obs_instr !== instr_of(obs_exp)) begin
          n_bad++;
          $display("FAIL collide_pop: pc=%h instr=%h want pc=%h", obs_pc, obs_instr, obs_exp);
        end
      end
    end
    n_cmp++;
    if (first_k != 2 || first_pc !== 32'h200) begin
      n_bad++;
      $display("FAIL collide_redirect: first valid @%0d pc=%h want @2 pc=00000200", first_k, first_pc);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b0; lat = 1;
    repeat (8) tick();
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_req !== 1'b0) begin
      n_bad++;
      $display("FAIL areset_full: valid=%b req=%b want 1/0", obs_valid, obs_req);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (if_valid !== 1'b0 || if_pc !== '0 || if_instr !== '0 || imem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_async: valid=%b pc=%h instr=%h req=%b want 0/0/0/1", if_valid, if_pc, if_instr, imem_req);
    end
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (obs_pop) begin
        n_cmp++;
        if (!obs_have || obs_pc !== obs_exp || obs_instr !== instr_of(obs_exp)) begin
          n_bad++;
          $display("FAIL areset_restart: pc=%h instr=%h want pc=%h", obs_pc, obs_instr, obs_exp);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; imem_gnt = 1'b0; id_ready = 1'b0; flush = 1'b0;
    cur_pc = '0; imem_rvalid = 1'b0; imem_rdata = '0; cyc = 0; lat = 1;
    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_stall();
    test_flush();
    test_flush_collide();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
